// File: rtl/quad_sync_sink_pkg.sv
// Shared types and helpers for the quad-rail sink: FSM states, completion
// polarity and 1-of-4 decode utilities.
package quad_sync_sink_pkg;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_e;

  localparam logic REQ_DATA = 1'b0;
  localparam logic REQ_NULL = 1'b1;

  function automatic logic [2:0] popcount4(input logic [3:0] q);
    return {2'b00, q[0]} + {2'b00, q[1]} + {2'b00, q[2]} + {2'b00, q[3]};
  endfunction

  function automatic logic is_onehot(input logic [3:0] q);
    return popcount4(q) == 3'd1;
  endfunction

  // Only meaningful for one-hot input; anything else maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] q);
    logic [1:0] idx;
    case (q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/quad_sync_sink_fifo.sv
// Small synchronous FIFO holding decoded requester IDs; head is
// registered storage so it stays put until popped.
module quad_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              level_q, level_d;
  logic                        do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    // A full FIFO can still accept when the same cycle frees an entry.
    do_push  = push && ((level_q != (PTR_W+1)'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (level_q != '0);
  assign level = level_q;

endmodule

// File: rtl/quad_sync_sink.sv
// Clocked sink for a 1-of-4 quad-rail channel: synchronises the rails,
// handshakes DATA/NULL wavefronts via quadCOMP and queues winner IDs.
module quad_sync_sink
  import quad_sync_sink_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic [3:0]               quad,
  output logic                     quadCOMP,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_id,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [4*CNT_W-1:0]       grant_cnt,
  output logic                     err_multi
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0][CNT_W-1:0]       grant_cnt_q, grant_cnt_d;
  state_e                      state_q, state_d;
  logic                        err_multi_q, err_multi_d;
  logic [3:0]                  qs, qn;
  logic                        stable, push, pop, fifo_valid;
  logic [1:0]                  push_idx;

  // Stability compares the last two synchroniser stages: two consecutive
  // samples of the rail, evaluated one cycle earlier than a separate qp flop.
  assign qs     = sync_q[SYNC_STAGES-1];
  assign qn     = sync_q[SYNC_STAGES-2];
  assign stable = (qs == qn);
  assign pop    = fifo_valid && out_ready;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], quad};
    state_d     = state_q;
    err_multi_d = err_multi_q;
    grant_cnt_d = grant_cnt_q;
    push        = 1'b0;
    push_idx    = onehot_to_idx(qs);
    case (state_q)
      WAIT_DATA: begin
        if (stable) begin
          if (is_onehot(qs)) begin
            if ((fifo_level < LVL_W'(DEPTH)) || pop) begin
              push                  = 1'b1;
              grant_cnt_d[push_idx] = grant_cnt_q[push_idx] + CNT_W'(1);
              state_d               = WAIT_NULL;
            end
          end else if (popcount4(qs) >= 3'd2) begin
            err_multi_d = 1'b1;
            state_d     = WAIT_NULL;
          end
        end
      end
      WAIT_NULL: begin
        if (stable && (qs == '0)) begin
          state_d = WAIT_DATA;
        end
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      sync_q      <= '0;
      state_q     <= WAIT_DATA;
      err_multi_q <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      err_multi_q <= err_multi_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  quad_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .init      (init),
    .push      (push),
    .push_data (push_idx),
    .pop       (pop),
    .head      (out_id),
    .valid     (fifo_valid),
    .level     (fifo_level)
  );

  assign quadCOMP  = (state_q == WAIT_NULL) ? REQ_NULL : REQ_DATA;
  assign out_valid = fifo_valid;
  assign grant_cnt = grant_cnt_q;
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_quad_sync_sink.sv
// Directed scoreboard bench for quad_sync_sink (DEPTH=4, CNT_W=3).
module tb_quad_sync_sink;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic                 clk = 1'b0;
  logic                 init;
  logic [3:0]           quad;
  logic                 quadCOMP;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_id;
  logic [2:0]           fifo_level;
  logic [4*CNT_W-1:0]   grant_cnt;
  logic                 err_multi;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [1:0] sb[$];
  logic [CNT_W-1:0] exp_cnt [4];

  quad_sync_sink #(
    .DEPTH       (DEPTH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .init       (init),
    .quad       (quad),
    .quadCOMP   (quadCOMP),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .fifo_level (fifo_level),
    .grant_cnt  (grant_cnt),
    .err_multi  (err_multi)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] q);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (q[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [4*CNT_W-1:0] exp_grant();
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
  endfunction

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
  endtask

  // Drives one wavefront just before edge k; quadCOMP is checked at k, k+1, k+2
  // and, if do_null, the NULL fall two edges after the rails drop.
  task automatic wave(input logic [3:0] q, input bit exp_comp, input bit exp_push, input bit do_null);
    quad = q;
    if (exp_push) begin
      sb.push_back(idx_of(q));
      exp_cnt[idx_of(q)] = exp_cnt[idx_of(q)] + 1'b1;
    end
    tick(1); chk("comp_k0", 32'(quadCOMP), 32'd0);
    tick(1); chk("comp_k1", 32'(quadCOMP), 32'd0);
    tick(1); chk("comp_k2", 32'(quadCOMP), 32'(exp_comp));
    if (do_null) begin
      quad = 4'b0000;
      tick(1); chk("null_m0", 32'(quadCOMP), 32'(exp_comp));
      tick(1); chk("null_m1", 32'(quadCOMP), 32'(exp_comp));
      tick(1); chk("null_m2", 32'(quadCOMP), 32'd0);
    end
  endtask

  task automatic pop_one();
    logic [1:0] exp_id;
    exp_id = (sb.size() != 0) ? sb.pop_front() : 2'b00;
    chk("pop_valid", 32'(out_valid), 32'd1);
    chk("pop_id", 32'(out_id), 32'(exp_id));
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    init = 1'b0;
    quad = 4'b0000;
    out_ready = 1'b0;
    clear_model();
    tick(3);
    chk("rst_comp", 32'(quadCOMP), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_grant", 32'(grant_cnt), 32'd0);
    chk("rst_err", 32'(err_multi), 32'd0);
    init = 1'b1;
    tick(1);

    // Basic wavefront on requester 2
    wave(4'b0100, 1'b1, 1'b1, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_id", 32'(out_id), 32'd2);
    chk("basic_grant", 32'(grant_cnt), 32'(exp_grant()));
    quad = 4'b0000;
    tick(1); chk("basic_null0", 32'(quadCOMP), 32'd1);
    tick(1); chk("basic_null1", 32'(quadCOMP), 32'd1);
    tick(1); chk("basic_null2", 32'(quadCOMP), 32'd0);
    pop_one();
    chk("basic_level", 32'(fifo_level), 32'd0);

    // Fill the FIFO, then backpressure
    wave(4'b0001, 1'b1, 1'b1, 1'b1);
    wave(4'b0010, 1'b1, 1'b1, 1'b1);
    wave(4'b1000, 1'b1, 1'b1, 1'b1);
    wave(4'b0001, 1'b1, 1'b1, 1'b1);
    chk("full_level", 32'(fifo_level), 32'd4);
    wave(4'b0010, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("full_hold_comp", 32'(quadCOMP), 32'd0);
    chk("full_hold_level", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    chk("full_pop_id", 32'(out_id), 32'(sb.pop_front()));
    sb.push_back(2'd1);
    exp_cnt[1] = exp_cnt[1] + 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("full_swap_comp", 32'(quadCOMP), 32'd1);
    chk("full_swap_level", 32'(fifo_level), 32'd4);
    quad = 4'b0000;
    tick(3);
    chk("full_null", 32'(quadCOMP), 32'd0);
    chk("full_grant", 32'(grant_cnt), 32'(exp_grant()));
    for (int i = 0; i < 4; i++) pop_one();
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Stable multi-hot, then a clean wavefront
    wave(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("multi_err", 32'(err_multi), 32'd1);
    chk("multi_level", 32'(fifo_level), 32'd0);
    wave(4'b1000, 1'b1, 1'b1, 1'b1);
    chk("multi_err_sticky", 32'(err_multi), 32'd1);
    pop_one();

    // Skewed rails settling to multi-hot
    quad = 4'b0001;
    tick(1);
    quad = 4'b0011;
    tick(1); chk("skew_a1", 32'(quadCOMP), 32'd0);
    tick(1); chk("skew_a2", 32'(quadCOMP), 32'd0);
    tick(1); chk("skew_a3", 32'(quadCOMP), 32'd1);
    chk("skew_level", 32'(fifo_level), 32'd0);
    quad = 4'b0000;
    tick(3);
    chk("skew_null", 32'(quadCOMP), 32'd0);

    // Single-cycle glitch
    quad = 4'b0100;
    tick(1);
    quad = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("glitch_comp", 32'(quadCOMP), 32'd0);
    end
    chk("glitch_level", 32'(fifo_level), 32'd0);
    chk("glitch_grant", 32'(grant_cnt), 32'(exp_grant()));

    // Reset, then counter wrap on requester 1
    init = 1'b0;
    tick(1);
    init = 1'b1;
    clear_model();
    chk("rst2_err", 32'(err_multi), 32'd0);
    chk("rst2_grant", 32'(grant_cnt), 32'd0);
    for (int i = 0; i < 9; i++) begin
      wave(4'b0010, 1'b1, 1'b1, 1'b1);
      pop_one();
    end
    chk("wrap_grant", 32'(grant_cnt), 32'h008);
    chk("wrap_grant_model", 32'(grant_cnt), 32'(exp_grant()));

    // Reset while in WAIT_NULL with two entries queued
    wave(4'b0001, 1'b1, 1'b1, 1'b1);
    wave(4'b0100, 1'b1, 1'b1, 1'b0);
    chk("mid_level", 32'(fifo_level), 32'd2);
    chk("mid_comp", 32'(quadCOMP), 32'd1);
    init = 1'b0;
    tick(1);
    clear_model();
    chk("mid_rst_comp", 32'(quadCOMP), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_grant", 32'(grant_cnt), 32'd0);
    init = 1'b1;
    quad = 4'b0000;
    tick(3);
    chk("post_rst_comp", 32'(quadCOMP), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
